// File: rtl/tp_skid_if.sv
// Bundle-side signals of the two-entry skid buffer, grouped for the upstream
// latch / downstream stage (master) and the buffer itself (slave).
interface tp_skid_if;
  logic [319:0] in;
  logic         flush;
  logic         ds_stall;
  logic         stall;
  logic [319:0] out;
  logic         out_v;
  logic [15:0]  stall_cnt;
  logic [1:0]   dbg_count;

  modport master (
    output in, flush, ds_stall,
    input  stall, out, out_v, stall_cnt, dbg_count
  );

  modport slave (
    input  in, flush, ds_stall,
    output stall, out, out_v, stall_cnt, dbg_count
  );
endinterface

// File: rtl/tp_skid.sv
// Two-entry skid buffer behind a pipeline latch: registered stall upstream,
// in-order head entry downstream, full flush and a saturating stall counter.
module tp_skid (
  input  logic       clk,
  input  logic       rst,
  tp_skid_if.slave   bus
);
  // Handshake: an input bundle transfers on an edge where in[0]=1, stall=0 and
  // flush=0; the head transfers on an edge where out_v=1, ds_stall=0, flush=0.
  logic [319:0] e0, e1;
  logic         rd_ptr, wr_ptr;
  logic [1:0]   count;
  logic [15:0]  stall_cnt_q;

  logic         stall_w, out_v_w, enq, deq;
  logic [319:0] head;

  always_comb begin
    stall_w = (count == 2'd2);
    out_v_w = (count != 2'd0);
    enq     = bus.in[0] & ~stall_w & ~bus.flush;
    deq     = out_v_w & ~bus.ds_stall & ~bus.flush;
    head    = rd_ptr ? e1 : e0;
  end

  assign bus.stall     = stall_w;
  assign bus.out_v     = out_v_w;
  assign bus.out       = {head[319:1], out_v_w};
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.dbg_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0          <= '0;
      e1          <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      // Stall is counted on the edge regardless of a concurrent flush.
      if (stall_w && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;

      if (bus.flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (enq) begin
          if (wr_ptr) e1 <= bus.in;
          else        e0 <= bus.in;
          wr_ptr <= ~wr_ptr;
        end
        if (deq)
          rd_ptr <= ~rd_ptr;
        if (enq && !deq)
          count <= count + 2'd1;
        else if (deq && !enq)
          count <= count - 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_tp_skid.sv
// Self-checking bench for tp_skid: cycle driver with a queue-level reference
// model, and a negedge monitor that pops expected head entries on each dequeue.
module tb_tp_skid;
  logic clk;
  logic rst;
  tp_skid_if bus ();

  tp_skid dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  logic [319:0] exp_q[$];
  int           m_cnt;      // entries held by the model during the current cycle
  int           m_scnt;     // expected stall_cnt during the current cycle
  bit           mon_en;
  int           n_cmp;
  int           n_bad;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [318:0] rnd_pl();
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom();
    t[0] = 1'b1;  // guarantees a nonzero payload
    return t[318:0];
  endfunction

  // ---------------- driver tasks ----------------
  // One clock cycle of stimulus; acc reports whether the model accepted the bundle.
  task automatic step(input logic v, input logic [318:0] pl, input logic ds,
                      input logic fl, output logic acc);
    logic en, de;
    bus.in       = {pl, v};
    bus.ds_stall = ds;
    bus.flush    = fl;
    en  = v && (m_cnt != 2) && !fl;
    de  = (m_cnt != 0) && !ds && !fl;
    acc = en;
    if (fl) exp_q.delete();
    else if (en) exp_q.push_back({pl, 1'b1});
    @(posedge clk);
    if (m_cnt == 2 && m_scnt != 16'hFFFF) m_scnt++;
    if (fl) m_cnt = 0;
    else    m_cnt = m_cnt + int'(en) - int'(de);
    #1;
  endtask

  // Present a bundle and keep it on the bus until the buffer takes it.
  task automatic send_hold(input logic [318:0] pl, input logic ds);
    logic acc;
    int   tries;
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, pl, ds, 1'b0, acc);
      tries++;
      ds = 1'b0;
    end
    n_cmp++;
    if (!acc) begin
      n_bad++;
      $display("FAIL send_hold_timeout: got 0 want 1");
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in       = '0;
    bus.flush    = 1'b1;
    bus.ds_stall = 1'b1;
    exp_q.delete();
    @(posedge clk);
    m_cnt  = 0;
    m_scnt = 0;
    #1;
    rst          = 1'b0;
    bus.flush    = 1'b0;
    bus.ds_stall = 1'b0;
    chk("rst_out",       bus.out, '0);
    chk("rst_out_v",     {319'd0, bus.out_v}, '0);
    chk("rst_stall",     {319'd0, bus.stall}, '0);
    chk("rst_stall_cnt", {304'd0, bus.stall_cnt}, '0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("out_v",     {319'd0, bus.out_v}, {319'd0, (m_cnt != 0)});
      chk("stall",     {319'd0, bus.stall}, {319'd0, (m_cnt == 2)});
      chk("out_bit0",  {319'd0, bus.out[0]}, {319'd0, bus.out_v});
      chk("count",     {318'd0, bus.dbg_count}, 320'(m_cnt));
      chk("stall_cnt", {304'd0, bus.stall_cnt}, 320'(m_scnt));
      if (bus.out_v && !bus.ds_stall && !bus.flush) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL deq_underflow: got %h want none", bus.out);
        end else begin
          chk("deq_data", bus.out, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic acc;
    logic [318:0] pl;
    n_cmp        = 0;
    n_bad        = 0;
    mon_en       = 0;
    m_cnt        = 0;
    m_scnt       = 0;
    rst          = 1'b1;
    bus.in       = '0;
    bus.flush    = 1'b0;
    bus.ds_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    mon_en = 1;

    // Streaming: five back-to-back bundles.
    for (int i = 0; i < 5; i++) step(1'b1, rnd_pl(), 1'b0, 1'b0, acc);
    idle(3);

    // Skid: A1 becomes head, then ds_stall for 3 cycles while A2, A3 arrive.
    step(1'b1, rnd_pl(), 1'b0, 1'b0, acc);
    step(1'b1, rnd_pl(), 1'b1, 1'b0, acc);
    pl = rnd_pl();
    step(1'b1, pl, 1'b1, 1'b0, acc);
    step(1'b1, pl, 1'b1, 1'b0, acc);
    send_hold(pl, 1'b0);
    idle(4);
    chk("skid_stall_cnt", {304'd0, bus.stall_cnt}, 320'd3);

    // Invalid input with nonzero payload never enqueues.
    for (int i = 0; i < 4; i++) step(1'b0, rnd_pl(), 1'b0, 1'b0, acc);

    // Flush while full, together with valid B1; then B2 follows.
    step(1'b1, rnd_pl(), 1'b1, 1'b0, acc);
    step(1'b1, rnd_pl(), 1'b1, 1'b0, acc);
    step(1'b1, rnd_pl(), 1'b1, 1'b1, acc);
    chk("flush_out_v", {319'd0, bus.out_v}, '0);
    chk("flush_stall", {319'd0, bus.stall}, '0);
    step(1'b1, rnd_pl(), 1'b0, 1'b0, acc);
    idle(3);

    // Pointer wrap: 20 bundles with ds_stall alternating.
    for (int i = 0; i < 20; i++) send_hold(rnd_pl(), logic'(i % 2 == 0));
    idle(4);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(logic'($urandom_range(0, 3) != 0), rnd_pl(),
           logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 29) == 0), acc);
    idle(4);
    chk("drain_empty", 320'(exp_q.size()), '0);

    // Saturation: fill to two entries and stall far past 16 bits.
    step(1'b1, rnd_pl(), 1'b1, 1'b0, acc);
    step(1'b1, rnd_pl(), 1'b1, 1'b0, acc);
    for (int i = 0; i < 70000; i++) step(1'b0, '0, 1'b1, 1'b0, acc);
    chk("sat_stall_cnt", {304'd0, bus.stall_cnt}, {304'd0, 16'hFFFF});
    chk("sat_full",      {319'd0, bus.stall}, 320'd1);

    // Reset while full clears everything, including stall_cnt.
    do_reset();
    step(1'b1, rnd_pl(), 1'b0, 1'b0, acc);
    idle(3);
    chk("final_empty", 320'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tp_skid.md
# tp_skid

Two-entry skid buffer on the consuming side of a pipeline latch. It reads the packed 320-bit stage bundle that a pipeline latch presents (valid in bit 0) and hands entries to the downstream stage in order. It returns a registered stall to the upstream latch, so downstream back-pressure never forms a combinational path back through the latch. It also supports a full flush and counts stall cycles for performance.

## Interface
- No parameters; bundle width fixed at 320, depth fixed at 2.
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- in  in  320  bundle from upstream latch; in[0] = valid, in[319:1] = payload (CS, addresses, operands, EIPs, regs, fetch ID)
- flush  in  1  discard all held entries and the current input
- ds_stall  in  1  downstream cannot take out this cycle
- stall  out  1  to upstream latch stall input; registered, depends only on state
- out  out  320  head entry; out[0] equals out_v
- out_v  out  1  head entry valid
- stall_cnt  out  16  cycles with stall high, saturating

## Operation
- State:
  - two 320-bit entries e0 and e1
  - 1-bit rd_ptr and wr_ptr
  - 2-bit count in {0,1,2}
  - stall_cnt
- Enqueue (enq) = in[0] & ~stall & ~flush. Writes in into entry[wr_ptr], then wr_ptr toggles.
- Dequeue (deq) = out_v & ~ds_stall & ~flush. rd_ptr toggles.
- Count update:
  - enq & ~deq: count + 1
  - deq & ~enq: count − 1
  - both or neither: count unchanged
- stall = (count == 2). Because stall is Moore, one entry can arrive while count==1 and downstream is stalled; e1 is the skid slot for that entry.
- out = entry[rd_ptr] with bit 0 replaced by out_v. out_v = (count != 0).
- Flush has priority over everything:
  - Next state: count=0, rd_ptr=wr_ptr=0.
  - The same-cycle input is dropped.
  - Entry contents need not be cleared.
- stall_cnt increments on every edge where stall==1. It holds at 16'hFFFF and is cleared only by rst; flush does not clear it.
- Invariants:
  - Order is preserved: no entry is dropped (except on flush) and none is duplicated.
  - count never exceeds 2. When count==2, enq is impossible because stall==1.
  - in with in[0]==0 never enqueues, whatever its payload.

## Timing
- Reset values: count=0, rd_ptr=wr_ptr=0, e0=e1=0, out=0, out_v=0, stall=0, stall_cnt=0.
- Latency: an entry accepted at edge N appears on out with out_v=1 after edge N, so minimum latency is 1 cycle. There is no combinational in-to-out bypass.
- Throughput: with ds_stall=0 and in[0]=1 every cycle, one entry per cycle. count stays at 1 and stall stays 0.
- Back-pressure:
  - ds_stall rises while count==1 and a valid input is present: count becomes 2 after that edge, and stall becomes 1 in the next cycle.
  - Upstream sees stall one cycle after ds_stall rises.
- Release: ds_stall falls while count==2. deq happens that cycle, count becomes 1, and stall is 0 in the following cycle.
- Simultaneous enq and deq at count==1: the old head leaves, the new entry becomes head, and count stays 1.
- Flush together with any of ds_stall, in[0], or count==2: next cycle has out_v=0 and stall=0.
- rst mid-operation overrides flush and all traffic. All state returns to reset values on that edge.

## Test plan
- Streaming: rst, then bundles with payload A1..A5 (in[0]=1) on 5 consecutive cycles with ds_stall=0.
  - out shows A1..A5 on cycles 2..6.
  - stall stays 0 and stall_cnt stays 0.
- Skid: hold ds_stall=1 starting with the cycle A1 is head, in continues with A2, A3.
  - A2 is accepted and count becomes 2; stall=1 the next cycle; upstream holds A3.
  - Drop ds_stall after 3 stalled cycles: out shows A1, A2, A3 in order with no loss.
  - stall_cnt=3.
- Invalid input: in with payload nonzero and in[0]=0 for 4 cycles → out_v stays 0 and count stays 0.
- Flush while full: count==2 and ds_stall=1, then assert flush together with valid input B1.
  - Next cycle out_v=0 and stall=0.
  - B2 sent afterwards appears 1 cycle later.
- Pointer wrap: alternate ds_stall 1/0 over 20 valid inputs C1..C20.
  - The output sequence equals the input sequence exactly.
  - Both pointers wrap multiple times.
- Reset mid-operation and saturation:
  - Force 70000 stalled cycles: stall_cnt holds at 16'hFFFF.
  - Assert rst with count==2: all outputs are 0 next cycle, including stall_cnt.
